// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: byte-alignment receiver for an MSB-first serial stream.
// Finds byte phase from the idle comma, declares lock after COMMA_LOCK aligned
// commas, then emits one parallel byte per boundary with a strobe and a valid
// flag (valid only for non-comma bytes). Single bit-rate clock throughout.
`timescale 1ns/1ps

module serial_paralelo_rx #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned COMMA_LOCK = 4
) (
    input  logic       clk32_f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active_out
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_CNT = 4'(COMMA_LOCK);

    state_t     r_state;
    state_t     w_state_nxt;

    // Only the last seven received bits are ever needed: together with the
    // incoming bit they form the byte window completed this cycle.
    logic [6:0] r_sr;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_cnt_nxt;
    logic [3:0] r_comma_cnt;
    logic [3:0] w_comma_cnt_nxt;

    logic [7:0] r_data;
    logic [7:0] w_data_nxt;
    logic       r_valid;
    logic       w_valid_nxt;
    logic       r_strobe;
    logic       w_strobe_nxt;
    logic       r_active;
    logic       w_active_nxt;

    logic [7:0] w_window;
    logic       w_is_comma;
    logic       w_boundary;

    assign w_window   = {r_sr, data_in};
    assign w_is_comma = (w_window == COMMA);
    assign w_boundary = (r_bit_cnt == 3'd7);

    assign data_out    = r_data;
    assign valid_out   = r_valid;
    assign byte_strobe = r_strobe;
    assign active_out  = r_active;

    // State register for the alignment FSM.
    always_ff @(posedge clk32_f) begin
        // NOTE: sequential state always uses non-blocking (<=) so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter and output decode for the alignment FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt + 3'd1;
        w_comma_cnt_nxt = r_comma_cnt;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_strobe_nxt    = 1'b0;
        w_active_nxt    = r_active;

        unique case (r_state)
            ST_SEARCH: begin
                // Any bit phase may complete a comma; a hit fixes the phase so
                // the next bit is the MSB of the following byte.
                if (w_is_comma) begin
                    w_bit_cnt_nxt   = 3'd0;
                    w_comma_cnt_nxt = 4'd1;
                    w_state_nxt     = ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                // Confirm the phase: only boundary windows are inspected.
                if (w_boundary) begin
                    if (w_is_comma) begin
                        w_comma_cnt_nxt = r_comma_cnt + 4'd1;
                        if ((r_comma_cnt + 4'd1) == LOCK_CNT) begin
                            w_state_nxt  = ST_LOCKED;
                            w_active_nxt = 1'b1;
                        end
                    end else begin
                        // Wrong phase (or false early match): hunt again
                        // starting with the next bit.
                        w_comma_cnt_nxt = 4'd0;
                        w_state_nxt     = ST_SEARCH;
                    end
                end
            end

            ST_LOCKED: begin
                // Lock is sticky; each boundary delivers one byte. A comma is
                // delivered too, but flagged as not valid.
                if (w_boundary) begin
                    w_data_nxt   = w_window;
                    w_strobe_nxt = 1'b1;
                    w_valid_nxt  = !w_is_comma;
                end
            end

            default: begin
                w_state_nxt     = ST_SEARCH;
                w_comma_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Shift register, counters and registered outputs.
    always_ff @(posedge clk32_f) begin
        // NOTE: only these few control/data registers are reset; there is no
        // memory array here, and reset also discards any partial byte.
        if (reset) begin
            r_sr        <= 7'd0;
            r_bit_cnt   <= 3'd0;
            r_comma_cnt <= 4'd0;
            r_data      <= 8'd0;
            r_valid     <= 1'b0;
            r_strobe    <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_sr        <= w_window[6:0];
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_comma_cnt <= w_comma_cnt_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_strobe    <= w_strobe_nxt;
            r_active    <= w_active_nxt;
        end
    end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb_serial_paralelo_rx: directed byte-table and corner-case sequences plus a
// randomized stream, all compared cycle by cycle against a behavioural model
// that tracks byte phase as an absolute cycle index.
`timescale 1ns/1ps

module tb_serial_paralelo_rx;

    localparam logic [7:0] BC   = 8'hBC;
    localparam int         LOCK = 4;

    localparam int M_SEARCHING = 0;
    localparam int M_ALIGNING  = 1;
    localparam int M_LOCKED    = 2;

    logic       clk32_f = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active_out;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural reference state.
    longint t      = 0;
    longint anchor = 0;
    int     m_hist = 0;
    int     m_mode = M_SEARCHING;
    int     m_cnt  = 0;
    int     m_data = 0;
    bit     m_valid  = 1'b0;
    bit     m_strobe = 1'b0;
    bit     m_active = 1'b0;

    typedef struct {
        logic [7:0] byte_in;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    serial_paralelo_rx #(.COMMA(8'hBC), .COMMA_LOCK(LOCK)) dut (
        .clk32_f     (clk32_f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active_out  (active_out)
    );

    always #5 clk32_f = ~clk32_f;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s at t=%0d: got %h expected %h", name, t, act, exp);
        else
            n_pass++;
    endtask

    // Reference model: the last 8 bits as an integer, and the byte phase as
    // the cycle index of the first comma seen; boundaries are every 8 cycles.
    task automatic model_update(input logic b, input logic r);
        int win;
        if (r) begin
            m_hist = 0; m_mode = M_SEARCHING; m_cnt = 0;
            m_data = 0; m_valid = 1'b0; m_strobe = 1'b0; m_active = 1'b0;
        end else begin
            win = (m_hist * 2 + (b ? 1 : 0)) % 256;
            m_valid  = 1'b0;
            m_strobe = 1'b0;
            if (m_mode == M_SEARCHING) begin
                if (win == int'(BC)) begin
                    anchor = t;
                    m_cnt  = 1;
                    m_mode = M_ALIGNING;
                end
            end else if (((t - anchor) % 8) == 0) begin
                if (m_mode == M_ALIGNING) begin
                    if (win == int'(BC)) begin
                        m_cnt++;
                        if (m_cnt == LOCK) begin
                            m_mode   = M_LOCKED;
                            m_active = 1'b1;
                        end
                    end else begin
                        m_mode = M_SEARCHING;
                        m_cnt  = 0;
                    end
                end else begin
                    m_data   = win;
                    m_strobe = 1'b1;
                    m_valid  = (win != int'(BC));
                end
            end
            m_hist = win;
        end
    endtask

    // One bit-time: drive, clock, then compare every output with the model.
    task automatic step(input logic b, input logic r);
        data_in = b;
        reset   = r;
        @(posedge clk32_f);
        #1;
        model_update(b, r);
        check("model data_out",    data_out,           8'(m_data));
        check("model valid_out",   8'(valid_out),      8'(m_valid));
        check("model byte_strobe", 8'(byte_strobe),    8'(m_strobe));
        check("model active_out",  8'(active_out),     8'(m_active));
        t++;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i], 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
    endtask

    task automatic lock_up();
        for (int i = 0; i < LOCK; i++) send_byte(BC);
        check("lock_up active", 8'(active_out), 8'd1);
    endtask

    vec_t       vecs[7];
    logic [7:0] rx_q[$];
    logic [7:0] tx_data[3];
    int         k;
    int         sel;
    logic [7:0] rb;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 8'hA5};
        vecs[1] = '{8'h3C, 1'b1, 8'h3C};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF};
        vecs[3] = '{8'hBC, 1'b0, 8'hBC};
        vecs[4] = '{8'h12, 1'b1, 8'h12};
        vecs[5] = '{8'h00, 1'b1, 8'h00};
        vecs[6] = '{8'h55, 1'b1, 8'h55};
        tx_data[0] = 8'h01;
        tx_data[1] = 8'h02;
        tx_data[2] = 8'h03;

        // Reset state.
        do_reset();
        check("reset data_out",    data_out,          8'h00);
        check("reset valid_out",   8'(valid_out),     8'd0);
        check("reset byte_strobe", 8'(byte_strobe),   8'd0);
        check("reset active_out",  8'(active_out),    8'd0);

        // Continuous comma stream at an arbitrary phase.
        k = $urandom_range(0, 7);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0);
        for (int i = 0; i < LOCK - 1; i++) send_byte(BC);
        check("idle before 4th comma active", 8'(active_out), 8'd0);
        send_byte(BC);
        check("idle 4th comma active", 8'(active_out), 8'd1);
        check("idle 4th comma no strobe", 8'(byte_strobe), 8'd0);
        for (int i = 0; i < 3; i++) begin
            send_byte(BC);
            check("idle strobe", 8'(byte_strobe), 8'd1);
            check("idle valid",  8'(valid_out),   8'd0);
            check("idle data",   data_out,        8'hBC);
        end

        // Byte table while locked.
        for (int i = 0; i < 7; i++) begin
            send_byte(vecs[i].byte_in);
            check("table strobe", 8'(byte_strobe), 8'd1);
            check("table valid",  8'(valid_out),   8'(vecs[i].exp_valid));
            check("table data",   data_out,        vecs[i].exp_data);
            step(1'b0, 1'b0);
            check("table strobe low", 8'(byte_strobe), 8'd0);
            for (int j = 0; j < 7; j++) step(1'b0, 1'b0);
            check("table zero byte", data_out, 8'h00);
        end

        // Misalignment: random bits, comma, non-comma, five commas.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'b0);
        send_byte(BC);
        send_byte(8'h55);
        for (int i = 0; i < 3; i++) begin
            send_byte(BC);
            check("misalign no early lock", 8'(active_out), 8'd0);
        end
        send_byte(BC);
        check("misalign lock on 4th", 8'(active_out), 8'd1);
        send_byte(BC);
        check("misalign 5th strobe", 8'(byte_strobe), 8'd1);

        // Bit slip: a comma at a false phase, three stray bits, true stream.
        do_reset();
        send_byte(BC);
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(BC);
        check("slip no lock yet", 8'(active_out), 8'd0);
        send_byte(BC);
        check("slip lock", 8'(active_out), 8'd1);
        send_byte(8'h12);
        check("slip data",  data_out,       8'h12);
        check("slip valid", 8'(valid_out),  8'd1);

        // Reset mid-byte while locked.
        do_reset();
        lock_up();
        send_byte(8'hA5);
        check("pre-reset data", data_out, 8'hA5);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("midreset data",   data_out,          8'h00);
        check("midreset valid",  8'(valid_out),     8'd0);
        check("midreset strobe", 8'(byte_strobe),   8'd0);
        check("midreset active", 8'(active_out),    8'd0);
        for (int i = 2; i >= 0; i--) begin
            rb = 8'hC3;
            step(rb[i], 1'b0);
            check("truncated no strobe", 8'(byte_strobe), 8'd0);
        end
        for (int i = 0; i < 3; i++) send_byte(BC);
        check("relock not early", 8'(active_out), 8'd0);
        send_byte(BC);
        check("relock active", 8'(active_out), 8'd1);

        // End-to-end: serializer sends data on alternate bytes, comma otherwise.
        do_reset();
        lock_up();
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            send_byte((i % 2 == 0) ? tx_data[i / 2] : BC);
            check("e2e strobe", 8'(byte_strobe), 8'd1);
            if (valid_out) rx_q.push_back(data_out);
            if (i % 2 == 1) check("e2e comma invalid", 8'(valid_out), 8'd0);
        end
        check("e2e count", 8'(rx_q.size()), 8'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < rx_q.size()) check("e2e byte", rx_q[i], tx_data[i]);
            else check("e2e byte missing", 8'h00, tx_data[i]);
        end

        // Randomized stream against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 2) begin
                do_reset();
            end else if (sel < 10) begin
                k = $urandom_range(1, 7);
                for (int i = 0; i < k; i++) step(1'($urandom_range(0, 1)), 1'b0);
            end else if (sel < 50) begin
                send_byte(BC);
            end else begin
                send_byte(8'($urandom_range(0, 255)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
- Downstream receive stage for the 8b serializer. Consumes the 1-bit MSB-first serial stream on clk32_f and recovers byte alignment from the 8'hBC idle comma.
- Emits parallel bytes with a valid flag and a per-byte strobe. Lock is declared after COMMA_LOCK consecutive aligned commas.
- Feeds the lane-level logic that replaces the clk4_f-domain byte path. A single clock is used; the byte rate is marked by strobe, not by a divided clock.

Parameters:
- COMMA, 8'hBC, idle/alignment symbol. Inserted by the transmitter when its valid input is low.
- COMMA_LOCK, 4, consecutive aligned commas (the first detection counts as 1) required to assert active_out. Range 2..15.

Ports:
- clk32_f  input  1  bit-rate clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial bit, MSB of each byte first.
- data_out  output  8  recovered byte.
- valid_out  output  1  high when data_out is a non-comma byte received while locked.
- byte_strobe  output  1  one-cycle pulse at every byte boundary while locked.
- active_out  output  1  lock indicator.

Behaviour:
- Reset, sampled on a clk32_f edge with reset=1:
  - data_out=0, valid_out=0, byte_strobe=0, active_out=0.
  - shift register=0, bit_cnt=0, comma_cnt=0, state=SEARCH.
  - Reset mid-operation discards the partial byte and lock; takes effect on that edge.
- Shift register: every non-reset cycle, sr <= {sr[6:0], data_in}. Define window = {sr[6:0], data_in}, the byte completed by the current bit.
- bit_cnt: 3-bit counter, increments every cycle and wraps 7->0. A boundary cycle is any cycle with bit_cnt==7.
- State SEARCH:
  - Window is checked every cycle.
  - If window==COMMA: bit_cnt<=0, comma_cnt<=1, state<=ALIGN. The next bit is bit 7 of the next byte.
  - Otherwise stay in SEARCH; the bit_cnt value is don't-care.
  - Outputs valid_out, byte_strobe and active_out stay 0.
- State ALIGN:
  - Window is checked only on boundary cycles.
  - window==COMMA: comma_cnt++. If the new count equals COMMA_LOCK, state<=LOCKED and active_out<=1 on the same edge.
  - window!=COMMA: state<=SEARCH, comma_cnt<=0. The mismatching window is not re-searched; the search resumes on the next bit.
  - Non-boundary cycles: hold.
- State LOCKED, on each boundary cycle:
  - data_out<=window.
  - byte_strobe<=1.
  - valid_out<=(window!=COMMA).
- State LOCKED, on non-boundary cycles: byte_strobe<=0 and valid_out<=0. data_out holds its last value.
- Latency: the last bit of a byte is sampled at edge N; data_out, valid_out and byte_strobe are visible after edge N. That is 1 cycle from the last bit and 8 cycles from the MSB.
- Lock persistence: LOCKED exits only on reset. A payload byte equal to COMMA is indistinguishable from idle and is reported with valid_out=0. This is consistent with the transmitter never sending 8'hBC as data.
- active_out rises exactly on the edge comma_cnt reaches COMMA_LOCK. It falls only on reset.
- Width rules:
  - comma_cnt is 4 bits and saturates at COMMA_LOCK.
  - bit_cnt wraps modulo 8.
  - No arithmetic on data bytes.
- Stream start:
  - The first 7 bits after reset cannot match COMMA unless the leading zeros of sr plus those bits form 8'hBC.
  - False early matches are legal. They are rejected in ALIGN if the next boundary window is not a comma.

Test Plan:
- Reset, then continuous 8'hBC stream MSB-first, arbitrary bit phase:
  - active_out rises after the 4th aligned comma completes.
  - byte_strobe then pulses every 8 cycles with valid_out=0 and data_out=8'hBC.
- Lock with 4 commas, then bytes 8'hA5, 8'h3C, 8'hFF:
  - Three strobes with valid_out=1 and data_out=A5, 3C, FF, each one cycle after its last bit.
  - The following idle BC gives a strobe with valid_out=0.
- Misalignment: send 3 random bits, then 8'hBC, then 8'h55 (not comma), then 5 commas:
  - The first BC enters ALIGN; 8'h55 drops back to SEARCH.
  - Lock is reached on the 4th of the 5 final commas; active_out=0 throughout before that.
- Bit-slip robustness: prefix the stream with bits producing a false BC window at a non-byte phase:
  - ALIGN rejects it at the next boundary.
  - Final lock is on the true byte phase, verified by correct data_out=8'h12 for a payload 8'h12.
- Reset mid-byte while LOCKED (reset high 1 cycle at bit 4 of payload 8'hC3):
  - All outputs 0 on the next cycle and state SEARCH.
  - Relock requires 4 fresh commas; no strobe for the truncated byte.
- End-to-end with the serializer on clk32_f, valid toggling every other byte, data 8'h01, 8'h02, 8'h03:
  - Received valid bytes match in order, with commas reported valid_out=0 in between.
